time_event_requester: RTL and testbench
=======================================

Name: time_event_requester

Overview:
- Client-side peer of the time manager. It proposes the time of its next event on a TIME_FORMAT request output, which feeds one entry of the manager's time_in array.
- It watches the registered global time_curr and fires a one-cycle event when global time reaches its proposal.
- It then advances its proposal by the next interval popped from a small period FIFO.
- Typical users: emulated oscillators, jittered clock edges, and data-edge generators.

Parameters:
- PERIOD_WIDTH, 16: width of each interval pushed into the FIFO, unsigned, in time LSBs.
- FIFO_DEPTH, 4: period FIFO entries; must be a power of 2 and at least 2.
- INIT_TIME, 0: value of last_time after reset; the first event fires at INIT_TIME + first period.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- time_curr  in  TIME_WIDTH (TIME_FORMAT)  registered global time from the time manager.
- time_req  out  TIME_WIDTH (TIME_FORMAT)  proposed next event time; drives one time_in entry.
- period_in  in  PERIOD_WIDTH  interval to the next event.
- period_valid  in  1  period_in is valid.
- period_ready  out  1  FIFO can accept; equals !full.
- event_pulse  out  1  one-cycle strobe; the event occurred this cycle.
- event_time  out  TIME_WIDTH  time of the most recent event (last_time).
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- starved  out  1  sticky: an event fired with the FIFO empty.
- missed  out  1  sticky: time_curr > time_req was seen while ARMED.
- overflow  out  1  sticky: next-time sum was clamped.

Behaviour:
- TIME_MAX = all ones. It is reserved as "no request" and never wins the manager's min.
- Reset values: time_req=TIME_MAX, event_pulse=0, event_time=INIT_TIME, fifo_count=0, period_ready=1, starved=0, missed=0, overflow=0. State=IDLE, FIFO emptied.
- Reset asserted mid-operation discards all FIFO contents and pending requests on that edge.
- FIFO:
  - A push occurs on an edge where period_valid && period_ready.
  - There is no bypass. A pushed entry is poppable no earlier than the next cycle.
  - A push and a pop on the same edge are both honoured; count is unchanged.
  - When full, period_ready=0 and period_valid is ignored.
- Zero period: treated as 1 at pop time. No flag is set. This prevents a self-sustaining time stall.
- next = last_time + period, computed at TIME_WIDTH+1 bits.
  - If next >= TIME_MAX, next is clamped to TIME_MAX-1 and overflow is set.
- State IDLE:
  - time_req=TIME_MAX.
  - If FIFO is non-empty: pop; time_req <= last_time + period; go ARMED.
- State ARMED:
  - time_req holds the proposal.
  - Fire condition: time_curr >= time_req.
  - On fire:
    - event_pulse=1 for that cycle only.
    - last_time/event_time <= time_req (the proposal, not time_curr).
    - If time_curr > time_req, missed is set.
    - If FIFO is non-empty: pop in the same edge; time_req <= time_req + period; stay ARMED.
    - If FIFO is empty: starved is set; time_req <= TIME_MAX; go IDLE.
  - No fire: hold.
- Back-to-back events: with the manager registering min(time_in), event k+1 fires at the earliest 2 cycles after event k. The new request is registered at the fire edge and appears on time_curr one edge later.
- Latency: push at edge t into an empty IDLE block gives time_req valid after edge t+1. The event fires in the first cycle after time_curr reaches that value.
- Simultaneous fire and push with an empty FIFO: the push does not bypass, so the block still starves and goes IDLE. The new entry is popped on the next cycle.
- time_curr is only sampled in ARMED. Global time advancing past a proposal in IDLE is not flagged.
- Sticky flags clear only on rst.

Test Plan:
- The bench models the manager with N=1 (time_curr <= time_req each edge, reset to 0) unless stated otherwise.
- Reset: assert rst 3 cycles -> time_req=TIME_MAX, event_time=0, fifo_count=0, period_ready=1, all flags 0.
- Steady clock:
  - Stimulus: push periods 10,10,10,10 (FIFO fills); keep refilling 10.
  - Required: events at event_time 10,20,30,40,… ; event_pulse exactly one cycle each; no flags set.
- Full/backpressure:
  - Stimulus: hold period_valid=1 with the event loop stalled (the bench holds time_curr=0).
  - Required: first push is popped, then 4 more accepted; period_ready=0 with fifo_count=4; further pushes are not accepted.
- Starvation:
  - Stimulus: push a single 5.
  - Required: event at 5; starved=1; time_req=TIME_MAX; state IDLE.
  - Follow-up: push 7 -> next event at 12.
- Missed and zero period:
  - Stimulus: bench forces time_curr to 20 while time_req=15.
  - Required: fire with event_time=15 and missed=1.
  - Separately, a pushed period of 0 -> next proposal = last_time+1.
- Overflow:
  - Stimulus: INIT_TIME=TIME_MAX-3, push period 8.
  - Required: time_req=TIME_MAX-1 and overflow=1.
  - Reset mid-run with FIFO count 3 -> count 0, time_req=TIME_MAX on the next cycle.

Source files
------------

// File: rtl/time_event_requester.sv
// time_event_requester
//   Client-side peer of the time manager. Proposes the time of its next event
//   on time_req, watches the registered global time (time_curr) and emits a
//   one-cycle event_pulse when global time reaches the proposal. After each
//   event the proposal advances by the next interval popped from a small
//   period FIFO.
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   time_curr     registered global time from the time manager
//   time_req      proposed next event time (all ones = no request)
//   period_in     interval to the next event, in time LSBs
//   period_valid  period_in is valid
//   period_ready  FIFO can accept a period (not full)
//   event_pulse   one-cycle strobe: the event occurred this cycle
//   event_time    time of the most recent event
//   fifo_count    current FIFO occupancy
//   starved       sticky: an event fired with the FIFO empty
//   missed        sticky: global time passed the proposal while armed
//   overflow      sticky: a next-time sum was clamped

module time_event_requester #(
  parameter int                    TIME_WIDTH   = 32,
  parameter int                    PERIOD_WIDTH = 16,
  parameter int                    FIFO_DEPTH   = 4,
  parameter logic [TIME_WIDTH-1:0] INIT_TIME    = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [TIME_WIDTH-1:0]              time_curr,
  output logic [TIME_WIDTH-1:0]              time_req,
  input  logic [PERIOD_WIDTH-1:0]            period_in,
  input  logic                               period_valid,
  output logic                               period_ready,
  output logic                               event_pulse,
  output logic [TIME_WIDTH-1:0]              event_time,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
  output logic                               starved,
  output logic                               missed,
  output logic                               overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // All ones is reserved as "no request"; the largest legal proposal is one below it.
  localparam logic [TIME_WIDTH-1:0] TIME_MAX   = '1;
  localparam logic [TIME_WIDTH-1:0] TIME_CLAMP = {{(TIME_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [CW-1:0]         FULL_COUNT = CW'(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  // Next proposal = base + period at TIME_WIDTH+1 bits. A zero period counts
  // as 1 so the block can never hold global time still. MSB of the result is
  // the clamp flag, the low bits are the (possibly clamped) proposal.
  function automatic logic [TIME_WIDTH:0] calc_next(
    input logic [TIME_WIDTH-1:0]   base,
    input logic [PERIOD_WIDTH-1:0] period
  );
    logic [PERIOD_WIDTH-1:0] p_eff;
    logic [TIME_WIDTH:0]     sum;
    p_eff = (period == '0) ? PERIOD_WIDTH'(1) : period;
    sum   = {1'b0, base} + (TIME_WIDTH+1)'(p_eff);
    if (sum >= {1'b0, TIME_MAX}) begin
      calc_next = {1'b1, TIME_CLAMP};
    end else begin
      calc_next = {1'b0, sum[TIME_WIDTH-1:0]};
    end
  endfunction

  logic [0:0]              state_q, state_d;
  logic [TIME_WIDTH-1:0]   time_req_q, time_req_d;
  logic [TIME_WIDTH-1:0]   last_time_q, last_time_d;
  logic                    event_pulse_q, event_pulse_d;
  logic                    starved_q, starved_d;
  logic                    missed_q, missed_d;
  logic                    overflow_q, overflow_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PERIOD_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PERIOD_WIDTH-1:0] fifo_mem_d [FIFO_DEPTH];

  logic                    full_s;
  logic                    empty_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    fire_s;
  logic [TIME_WIDTH-1:0]   base_s;
  logic [TIME_WIDTH:0]     next_s;

  assign full_s  = (count_q == FULL_COUNT);
  assign empty_s = (count_q == CW'(0));
  assign push_s  = period_valid && !full_s;
  assign fire_s  = (state_q == ST_ARMED) && (time_curr >= time_req_q);
  // In ARMED the new proposal chains from the proposal that just fired,
  // which is exactly what last_time becomes on that edge.
  assign base_s  = (state_q == ST_ARMED) ? time_req_q : last_time_q;
  assign next_s  = calc_next(base_s, fifo_mem_q[rd_ptr_q]);

  // Event FSM: arm from IDLE, fire and re-arm or starve in ARMED.
  always_comb begin
    state_d       = state_q;
    time_req_d    = time_req_q;
    last_time_d   = last_time_q;
    event_pulse_d = 1'b0;
    starved_d     = starved_q;
    missed_d      = missed_q;
    overflow_d    = overflow_q;
    pop_s         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s      = 1'b1;
          time_req_d = next_s[TIME_WIDTH-1:0];
          overflow_d = overflow_q | next_s[TIME_WIDTH];
          state_d    = ST_ARMED;
        end else begin
          time_req_d = TIME_MAX;
          state_d    = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (fire_s) begin
          event_pulse_d = 1'b1;
          last_time_d   = time_req_q;
          missed_d      = missed_q | (time_curr > time_req_q);
          if (!empty_s) begin
            pop_s      = 1'b1;
            time_req_d = next_s[TIME_WIDTH-1:0];
            overflow_d = overflow_q | next_s[TIME_WIDTH];
            state_d    = ST_ARMED;
          end else begin
            starved_d  = 1'b1;
            time_req_d = TIME_MAX;
            state_d    = ST_IDLE;
          end
        end else begin
          state_d = ST_ARMED;
        end
      end
      default: begin
        time_req_d = TIME_MAX;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // Period FIFO bookkeeping; pop reads the pre-edge head, so a same-edge push never bypasses.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    if (push_s) begin
      wr_ptr_d              = wr_ptr_q + AW'(1);
      fifo_mem_d[wr_ptr_q]  = period_in;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      time_req_q    <= TIME_MAX;
      last_time_q   <= INIT_TIME;
      event_pulse_q <= 1'b0;
      starved_q     <= 1'b0;
      missed_q      <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      time_req_q    <= time_req_d;
      last_time_q   <= last_time_d;
      event_pulse_q <= event_pulse_d;
      starved_q     <= starved_d;
      missed_q      <= missed_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign time_req     = time_req_q;
  assign event_pulse  = event_pulse_q;
  assign event_time   = last_time_q;
  assign fifo_count   = count_q;
  assign period_ready = !full_s;
  assign starved      = starved_q;
  assign missed       = missed_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_time_event_requester.sv
module tb_time_event_requester;

  localparam int TW    = 32;
  localparam int PW    = 16;
  localparam int DEPTH = 4;
  localparam logic [TW-1:0] TMAX = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (INIT_TIME = 0)
  logic          rst;
  logic [TW-1:0] time_curr;
  logic [TW-1:0] time_req;
  logic [PW-1:0] period_in;
  logic          period_valid;
  logic          period_ready;
  logic          event_pulse;
  logic [TW-1:0] event_time;
  logic [2:0]    fifo_count;
  logic          starved, missed, overflow;

  // Overflow instance (INIT_TIME = TIME_MAX-3)
  logic          rst2;
  logic [TW-1:0] time_curr2;
  logic [TW-1:0] time_req2;
  logic [PW-1:0] period_in2;
  logic          period_valid2;
  logic          period_ready2;
  logic          event_pulse2;
  logic [TW-1:0] event_time2;
  logic [2:0]    fifo_count2;
  logic          starved2, missed2, overflow2;

  time_event_requester #(.TIME_WIDTH(TW), .PERIOD_WIDTH(PW), .FIFO_DEPTH(DEPTH),
                         .INIT_TIME(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .time_curr(time_curr), .time_req(time_req),
    .period_in(period_in), .period_valid(period_valid), .period_ready(period_ready),
    .event_pulse(event_pulse), .event_time(event_time), .fifo_count(fifo_count),
    .starved(starved), .missed(missed), .overflow(overflow));

  time_event_requester #(.TIME_WIDTH(TW), .PERIOD_WIDTH(PW), .FIFO_DEPTH(DEPTH),
                         .INIT_TIME(32'hFFFF_FFFC)) dut_ovf (
    .clk(clk), .rst(rst2), .time_curr(time_curr2), .time_req(time_req2),
    .period_in(period_in2), .period_valid(period_valid2), .period_ready(period_ready2),
    .event_pulse(event_pulse2), .event_time(event_time2), .fifo_count(fifo_count2),
    .starved(starved2), .missed(missed2), .overflow(overflow2));

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: a queue of periods, an armed flag and the proposal.
  logic [PW-1:0] m_q[$];
  bit            m_armed   = 1'b0;
  logic [TW-1:0] m_req     = TMAX;
  logic [TW-1:0] m_last    = '0;
  bit            m_pulse   = 1'b0;
  bit            m_starved = 1'b0;
  bit            m_missed  = 1'b0;
  bit            m_ovf     = 1'b0;
  bit            tc_hold   = 1'b0;

  function automatic logic [TW-1:0] advance(input logic [TW-1:0] base, input logic [PW-1:0] p);
    longint s;
    s = longint'(base) + ((p == 16'd0) ? 64'd1 : longint'(p));
    if (s >= longint'(TMAX)) begin
      m_ovf = 1'b1;
      return TMAX - 32'd1;
    end
    return s[TW-1:0];
  endfunction

  task automatic model_edge();
    bit            do_push;
    logic [PW-1:0] pin;
    if (rst) begin
      m_q.delete();
      m_armed = 0; m_req = TMAX; m_last = 32'd0; m_pulse = 0;
      m_starved = 0; m_missed = 0; m_ovf = 0;
    end else begin
      do_push = period_valid && (m_q.size() < DEPTH);
      pin     = period_in;
      m_pulse = 0;
      if (!m_armed) begin
        if (m_q.size() > 0) begin
          m_req   = advance(m_last, m_q.pop_front());
          m_armed = 1;
        end
      end else if (time_curr >= m_req) begin
        m_pulse = 1;
        if (time_curr > m_req) m_missed = 1;
        m_last = m_req;
        if (m_q.size() > 0) begin
          m_req = advance(m_req, m_q.pop_front());
        end else begin
          m_starved = 1; m_req = TMAX; m_armed = 0;
        end
      end
      if (do_push) m_q.push_back(pin);
    end
  endtask

  // One clock: model and DUT advance together, then the N=1 manager updates time_curr.
  task automatic step();
    logic [TW-1:0] req_before;
    req_before = m_req;
    @(posedge clk);
    model_edge();
    #1;
    if (rst) time_curr = 32'd0;
    else if (!tc_hold && req_before != TMAX) time_curr = req_before;
    check_val("time_req",     time_req,     m_req);
    check_val("event_pulse",  event_pulse,  m_pulse);
    check_val("event_time",   event_time,   m_last);
    check_val("fifo_count",   fifo_count,   m_q.size());
    check_val("period_ready", period_ready, (m_q.size() < DEPTH));
    check_val("starved",      starved,      m_starved);
    check_val("missed",       missed,       m_missed);
    check_val("overflow",     overflow,     m_ovf);
  endtask

  task automatic wait_pulse(input string tag, input int bound);
    bit found;
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      step();
      if (event_pulse) found = 1'b1;
    end
    if (!found) check_val({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; period_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  int          ev_count;
  logic [TW-1:0] exp_ev;
  bit          prev_pulse;

  initial begin
    rst = 1'b1; time_curr = '0; period_in = '0; period_valid = 1'b0;
    rst2 = 1'b1; time_curr2 = '0; period_in2 = '0; period_valid2 = 1'b0;

    // Reset
    repeat (3) step();
    check_val("rst_time_req",   time_req,     TMAX);
    check_val("rst_event_time", event_time,   32'd0);
    check_val("rst_fifo_count", fifo_count,   3'd0);
    check_val("rst_ready",      period_ready, 1'b1);
    check_val("rst_flags",      {starved, missed, overflow, event_pulse}, 4'd0);
    rst = 1'b0;

    // Steady clock of period 10
    exp_ev = 32'd0; ev_count = 0; prev_pulse = 1'b0;
    period_valid = 1'b1; period_in = 16'd10;
    for (int i = 0; i < 60; i++) begin
      step();
      if (event_pulse) begin
        exp_ev = exp_ev + 32'd10;
        ev_count++;
        check_val("steady_ev_time", event_time, exp_ev);
        check_val("pulse_width", prev_pulse, 1'b0);
      end
      prev_pulse = event_pulse;
    end
    check_val("steady_ev_count", (ev_count >= 20), 1'b1);
    check_val("steady_flags", {starved, missed, overflow}, 3'd0);

    // Full / backpressure with time held at 0
    do_reset();
    tc_hold = 1'b1; period_valid = 1'b1; period_in = 16'd10;
    repeat (8) step();
    check_val("bp_count", fifo_count,   3'd4);
    check_val("bp_ready", period_ready, 1'b0);
    check_val("bp_req",   time_req,     32'd10);

    // Starvation, then recovery
    do_reset();
    tc_hold = 1'b0; period_valid = 1'b1; period_in = 16'd5;
    step();
    period_valid = 1'b0;
    wait_pulse("starve_ev", 20);
    check_val("starve_ev_time", event_time, 32'd5);
    check_val("starve_flag",    starved,    1'b1);
    check_val("starve_req",     time_req,   TMAX);
    period_valid = 1'b1; period_in = 16'd7;
    step();
    period_valid = 1'b0;
    wait_pulse("recover_ev", 20);
    check_val("recover_ev_time", event_time, 32'd12);

    // Missed, then zero period
    do_reset();
    tc_hold = 1'b1; period_valid = 1'b1; period_in = 16'd15;
    step();
    period_valid = 1'b0;
    step(); step();
    check_val("miss_req", time_req, 32'd15);
    time_curr = 32'd20;
    step();
    check_val("miss_pulse",    event_pulse, 1'b1);
    check_val("miss_ev_time",  event_time,  32'd15);
    check_val("miss_flag",     missed,      1'b1);
    period_valid = 1'b1; period_in = 16'd0;
    step();
    period_valid = 1'b0;
    step();
    check_val("zero_req", time_req, 32'd16);
    step();
    check_val("zero_ev_time", event_time, 32'd16);

    // Reset mid-run with three entries queued
    do_reset();
    tc_hold = 1'b1; period_valid = 1'b1; period_in = 16'd9;
    repeat (4) step();
    check_val("midrst_count_pre", fifo_count, 3'd3);
    rst = 1'b1; period_valid = 1'b0;
    step();
    rst = 1'b0;
    check_val("midrst_count", fifo_count, 3'd0);
    check_val("midrst_req",   time_req,   TMAX);

    // Randomized traffic against the model
    tc_hold = 1'b0;
    for (int i = 0; i < 600; i++) begin
      period_valid = ($urandom_range(0, 2) != 0);
      period_in    = ($urandom_range(0, 7) == 0) ? PW'($urandom_range(0, 65535))
                                                 : PW'($urandom_range(0, 6));
      tc_hold      = ($urandom_range(0, 9) == 0);
      rst          = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; tc_hold = 1'b0; period_valid = 1'b0;

    // Overflow instance: INIT_TIME = TIME_MAX-3, push 8
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    check_val("ovf_init_time", event_time2, 32'hFFFF_FFFC);
    period_valid2 = 1'b1; period_in2 = 16'd8;
    @(posedge clk); #1;
    period_valid2 = 1'b0;
    @(posedge clk); #1;
    check_val("ovf_req",  time_req2, 32'hFFFF_FFFE);
    check_val("ovf_flag", overflow2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
